// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch controller.
//   ADDR_W        : default PC / redirect target width
//   INSTR_W       : default instruction word width
//   fetch_state_t : FETCH   - request outstanding, waiting for the response
//                   HOLD    - one fetched instruction parked while decode stalls
//                   DISCARD - in-flight fetch is stale and will be dropped
package fetch_pkg;

  localparam int ADDR_W  = 32;
  localparam int INSTR_W = 32;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    HOLD    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_skid_reg.sv
// One-entry instruction buffer used while the decode stage stalls.
//   clk, rst : clock, synchronous active-high reset
//   load     : capture d
//   clear    : empty the buffer (drives q to zero); wins over load
//   d        : incoming instruction word
//   q        : buffered instruction word
module fetch_skid_reg #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // NOTE: the buffer is a single word, so resetting it is cheap and keeps
  // IF_instr deterministic after reset; deep storage arrays would not be reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments for every sequential state update, so
    // all registers sample their inputs from the same pre-edge values.
    if (rst || clear) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch stage sequencer.
//   clk, rst      : clock, synchronous active-high reset
//   imem_read     : fetch request to I-memory at the current IF address
//   imem_resp     : I-memory response valid (single-cycle pulse)
//   imem_rdata    : I-memory response data
//   id_stall      : decode cannot accept an instruction this cycle
//   redir_valid   : MEM-stage redirect request (pulse)
//   redir_pc      : MEM-stage redirect target
//   pc_load       : load enable to the PC register
//   pcmux_sel     : 1 = PC takes jmp_pc, 0 = sequential/predicted path
//   jmp_pc        : redirect target presented to the PC mux
//   IF_valid      : IF_instr valid for the IF/ID register this cycle
//   IF_instr      : fetched instruction
//   busy_discard  : an in-flight fetch is marked for discard
module if_fetch_ctrl #(
  parameter int ADDR_W  = fetch_pkg::ADDR_W,
  parameter int INSTR_W = fetch_pkg::INSTR_W
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_read,
  input  logic               imem_resp,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               id_stall,
  input  logic               redir_valid,
  input  logic [ADDR_W-1:0]  redir_pc,
  output logic               pc_load,
  output logic               pcmux_sel,
  output logic [ADDR_W-1:0]  jmp_pc,
  output logic               IF_valid,
  output logic [INSTR_W-1:0] IF_instr,
  output logic               busy_discard
);

  import fetch_pkg::*;

  fetch_state_t        state, state_nxt;
  logic [ADDR_W-1:0]   pend_pc, pend_nxt;
  logic [INSTR_W-1:0]  buf_instr;
  logic                buf_load, buf_clear;

  fetch_skid_reg #(.W(INSTR_W)) u_skid (
    .clk   (clk),
    .rst   (rst),
    .load  (buf_load),
    .clear (buf_clear),
    .d     (imem_rdata),
    .q     (buf_instr)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= FETCH;
      pend_pc <= '0;
    end else begin
      state   <= state_nxt;
      pend_pc <= pend_nxt;
    end
  end

  always_comb begin
    // NOTE: every output and next-state value gets a default before the case
    // statement so no path leaves one unassigned and infers a latch.
    state_nxt    = state;
    pend_nxt     = pend_pc;
    imem_read    = 1'b0;
    pc_load      = 1'b0;
    pcmux_sel    = 1'b0;
    jmp_pc       = '0;
    IF_valid     = 1'b0;
    IF_instr     = '0;
    busy_discard = 1'b0;
    buf_load     = 1'b0;
    buf_clear    = 1'b0;

    // Outputs are forced quiet during reset, independent of the stored state.
    if (!rst) begin
      jmp_pc = redir_pc;
      unique case (state)
        FETCH: begin
          imem_read = 1'b1;
          IF_instr  = imem_rdata;
          if (imem_resp) begin
            if (redir_valid) begin
              // Response arrives together with a redirect: the data is on the
              // wrong path, so drop it and steer the PC immediately.
              pc_load   = 1'b1;
              pcmux_sel = 1'b1;
            end else if (!id_stall) begin
              IF_valid = 1'b1;
              pc_load  = 1'b1;
            end else begin
              buf_load  = 1'b1;
              state_nxt = HOLD;
            end
          end else if (redir_valid) begin
            // The fetch address must stay stable until the outstanding
            // response returns, so the redirect is parked in pend_pc.
            pend_nxt  = redir_pc;
            state_nxt = DISCARD;
          end
        end

        DISCARD: begin
          imem_read    = 1'b1;
          busy_discard = 1'b1;
          jmp_pc       = redir_valid ? redir_pc : pend_pc;
          if (redir_valid) begin
            pend_nxt = redir_pc;
          end
          if (imem_resp) begin
            pc_load   = 1'b1;
            pcmux_sel = 1'b1;
            state_nxt = FETCH;
          end
        end

        HOLD: begin
          IF_instr = buf_instr;
          IF_valid = !redir_valid;
          if (redir_valid) begin
            pc_load   = 1'b1;
            pcmux_sel = 1'b1;
            buf_clear = 1'b1;
            state_nxt = FETCH;
          end else if (!id_stall) begin
            pc_load   = 1'b1;
            buf_clear = 1'b1;
            state_nxt = FETCH;
          end
        end

        default: begin
          state_nxt = FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Directed self-checking bench for if_fetch_ctrl. Inputs change just after
// each falling edge; outputs are checked 1 ns later, well away from the
// rising edge where state updates.
module tb_if_fetch_ctrl;

  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_read;
  logic        imem_resp;
  logic [31:0] imem_rdata;
  logic        id_stall;
  logic        redir_valid;
  logic [31:0] redir_pc;
  logic        pc_load;
  logic        pcmux_sel;
  logic [31:0] jmp_pc;
  logic        IF_valid;
  logic [31:0] IF_instr;
  logic        busy_discard;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  if_fetch_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .imem_read    (imem_read),
    .imem_resp    (imem_resp),
    .imem_rdata   (imem_rdata),
    .id_stall     (id_stall),
    .redir_valid  (redir_valid),
    .redir_pc     (redir_pc),
    .pc_load      (pc_load),
    .pcmux_sel    (pcmux_sel),
    .jmp_pc       (jmp_pc),
    .IF_valid     (IF_valid),
    .IF_instr     (IF_instr),
    .busy_discard (busy_discard)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge and apply a new input vector.
  task automatic step(input logic r, input logic resp, input logic [31:0] rdata,
                      input logic stall, input logic rv, input logic [31:0] rpc);
    @(negedge clk);
    rst         = r;
    imem_resp   = resp;
    imem_rdata  = rdata;
    id_stall    = stall;
    redir_valid = rv;
    redir_pc    = rpc;
    #1;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, ".imem_read"},    imem_read,    0);
    check({tag, ".pc_load"},      pc_load,      0);
    check({tag, ".pcmux_sel"},    pcmux_sel,    0);
    check({tag, ".IF_valid"},     IF_valid,     0);
    check({tag, ".busy_discard"}, busy_discard, 0);
    check({tag, ".jmp_pc"},       jmp_pc,       0);
    check({tag, ".IF_instr"},     IF_instr,     0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; imem_resp = 1'b0; imem_rdata = '0; id_stall = 1'b0;
    redir_valid = 1'b0; redir_pc = '0;

    // Reset with busy-looking inputs: every output must stay at zero.
    step(1, 1, 32'h1234_5678, 0, 1, 32'h44);
    check_quiet("rst0");
    step(1, 0, 0, 0, 0, 0);
    check("rst0.state", dut.state, FETCH);

    // Leaving reset: FETCH, request raised, PC held.
    step(0, 0, 0, 0, 0, 0);
    check("idle.imem_read", imem_read, 1);
    check("idle.pc_load",   pc_load,   0);
    check("idle.IF_valid",  IF_valid,  0);

    // Streaming: a response every second cycle, no stall.
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 0, 0);
      check("stream.gap.pc_load",  pc_load,  0);
      check("stream.gap.IF_valid", IF_valid, 0);
      step(0, 1, 32'h0000_0013, 0, 0, 0);
      check("stream.IF_valid",  IF_valid,  1);
      check("stream.IF_instr",  IF_instr,  32'h13);
      check("stream.pc_load",   pc_load,   1);
      check("stream.pcmux_sel", pcmux_sel, 0);
    end

    // Stall hold: response captured while decode stalls.
    step(0, 1, 32'hDEAD_BEEF, 1, 0, 0);
    check("stall.cap.IF_valid", IF_valid, 0);
    check("stall.cap.pc_load",  pc_load,  0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 1, 0, 0);
      check("hold.IF_valid",  IF_valid,  1);
      check("hold.IF_instr",  IF_instr,  32'hDEAD_BEEF);
      check("hold.imem_read", imem_read, 0);
      check("hold.pc_load",   pc_load,   0);
    end
    step(0, 0, 0, 0, 0, 0);
    check("hold.rel.IF_valid",  IF_valid,  1);
    check("hold.rel.IF_instr",  IF_instr,  32'hDEAD_BEEF);
    check("hold.rel.pc_load",   pc_load,   1);
    check("hold.rel.pcmux_sel", pcmux_sel, 0);
    step(0, 0, 0, 0, 0, 0);
    check("hold.back.imem_read", imem_read, 1);
    check("hold.back.state",     dut.state, FETCH);

    // Late redirect: arrives two cycles before the response.
    step(0, 0, 0, 0, 1, 32'h60);
    check("late.req.busy_discard", busy_discard, 0);
    check("late.req.pc_load",      pc_load,      0);
    step(0, 0, 0, 0, 0, 32'h999);
    check("late.wait.busy_discard", busy_discard, 1);
    check("late.wait.jmp_pc",       jmp_pc,       32'h60);
    check("late.wait.pc_load",      pc_load,      0);
    check("late.wait.imem_read",    imem_read,    1);
    step(0, 1, 32'h1111_1111, 0, 0, 32'h999);
    check("late.resp.IF_valid",  IF_valid,  0);
    check("late.resp.pc_load",   pc_load,   1);
    check("late.resp.pcmux_sel", pcmux_sel, 1);
    check("late.resp.jmp_pc",    jmp_pc,    32'h60);
    step(0, 0, 0, 0, 0, 0);
    check("late.after.busy_discard", busy_discard, 0);

    // Two redirects while one fetch is in flight: the later target wins.
    step(0, 0, 0, 0, 1, 32'h200);
    step(0, 0, 0, 0, 1, 32'h240);
    check("latest.jmp_pc", jmp_pc, 32'h240);
    step(0, 1, 32'h2222_2222, 0, 0, 0);
    check("latest.resp.jmp_pc",    jmp_pc,    32'h240);
    check("latest.resp.pcmux_sel", pcmux_sel, 1);
    check("latest.resp.IF_valid",  IF_valid,  0);

    // Coincident response and redirect.
    step(0, 1, 32'h3333_3333, 0, 1, 32'h80);
    check("coinc.IF_valid",  IF_valid,  0);
    check("coinc.pc_load",   pc_load,   1);
    check("coinc.pcmux_sel", pcmux_sel, 1);
    check("coinc.jmp_pc",    jmp_pc,    32'h80);
    step(0, 0, 0, 0, 0, 0);
    check("coinc.state",        dut.state,    FETCH);
    check("coinc.busy_discard", busy_discard, 0);

    // Redirect while holding a stalled instruction.
    step(0, 1, 32'h0000_CAFE, 1, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    check("hredir.hold.IF_valid", IF_valid, 1);
    check("hredir.hold.IF_instr", IF_instr, 32'hCAFE);
    step(0, 0, 0, 1, 1, 32'h100);
    check("hredir.IF_valid",  IF_valid,  0);
    check("hredir.pc_load",   pc_load,   1);
    check("hredir.pcmux_sel", pcmux_sel, 1);
    check("hredir.jmp_pc",    jmp_pc,    32'h100);
    step(0, 0, 0, 0, 0, 0);
    check("hredir.state",     dut.state, FETCH);
    check("hredir.imem_read", imem_read, 1);

    // Reset in the middle of a discard.
    step(0, 0, 0, 0, 1, 32'h300);
    step(0, 0, 0, 0, 0, 0);
    check("mrst.pre.busy_discard", busy_discard, 1);
    check("mrst.pre.jmp_pc",       jmp_pc,       32'h300);
    step(1, 1, 32'h4444_4444, 0, 1, 32'h340);
    check_quiet("mrst");
    step(0, 0, 0, 0, 0, 32'h500);
    check("mrst.state",        dut.state,    FETCH);
    check("mrst.pend_pc",      dut.pend_pc,  0);
    check("mrst.busy_discard", busy_discard, 0);
    check("mrst.imem_read",    imem_read,    1);
    check("mrst.jmp_pc",       jmp_pc,       32'h500);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
